// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART bus arbiter.
// Holds the FSM state encoding, bus addresses and the baud divisor table.
package spart_pkg;

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      IDLE,
      RD_RX,
      WR_TX
   } state_t;

   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DB_LO  = 2'b10;
   localparam logic [1:0] ADDR_DB_HI  = 2'b11;

   localparam logic GNT_RX = 1'b0;
   localparam logic GNT_TX = 1'b1;

   function automatic logic [15:0] div_for(input logic [1:0] br);
      logic [15:0] d;
      unique case (br)
         2'b00:   d = 16'h0516;
         2'b01:   d = 16'h028B;
         2'b10:   d = 16'h0145;
         default: d = 16'h00A3;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/spart_tx_fifo.sv
// Small circular TX FIFO feeding SPART data-register writes.
// A push while full is accepted only when a pop frees the slot that cycle.
module spart_tx_fifo
   import spart_pkg::*;
#(
   parameter int TX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(TX_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(TX_DEPTH);

   logic [7:0]    mem [TX_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          wr_en;
   logic          rd_en;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign dout  = mem[rd_ptr];

   // Storage write; contents need no reset because count gates reads.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spart_bus_arbiter.sv
// Sole master of the SPART processor-side bus: divisor load,
// round-robin RX read / TX write scheduling, RX holding register.
module spart_bus_arbiter
   import spart_pkg::*;
#(
   parameter int TX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] br_cfg,
   input  logic       cfg_req,
   output logic       cfg_busy,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   input  logic       rda,
   input  logic       tbr,
   inout  wire  [7:0] databus
);

   state_t      state;
   logic        rst_q;
   logic [1:0]  br_q;
   logic        cfg_pending;
   logic        last_grant;
   logic [15:0] div;
   logic [7:0]  db_out;
   logic [7:0]  fifo_dout;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        rx_ok;
   logic        tx_ok;

   assign div      = div_for(br_q);
   assign tx_ready = ~fifo_full;
   assign push     = tx_valid & tx_ready;
   assign pop      = (state == WR_TX);
   assign rx_ok    = rda & ~rx_valid;
   assign tx_ok    = tbr & ~fifo_empty;
   assign cfg_busy = (state == CFG_LO) || (state == CFG_HI);
   assign databus  = (iocs & ~iorw) ? db_out : 8'hzz;

   spart_tx_fifo #(
      .TX_DEPTH(TX_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push),
      .din  (tx_data),
      .pop  (pop),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   // Moore bus decode; the reset cycle holds the bus quiet.
   always_comb begin
      iocs   = 1'b0;
      iorw   = 1'b1;
      ioaddr = ADDR_DATA;
      db_out = fifo_dout;
      if (!rst_q) begin
         case (state)
            CFG_LO: begin
               iocs   = 1'b1;
               iorw   = 1'b0;
               ioaddr = ADDR_DB_LO;
               db_out = div[7:0];
            end
            CFG_HI: begin
               iocs   = 1'b1;
               iorw   = 1'b0;
               ioaddr = ADDR_DB_HI;
               db_out = div[15:8];
            end
            RD_RX: begin
               iocs   = 1'b1;
               iorw   = 1'b1;
               ioaddr = ADDR_DATA;
            end
            WR_TX: begin
               iocs   = 1'b1;
               iorw   = 1'b0;
               ioaddr = ADDR_DATA;
            end
            default: begin
               iocs   = 1'b0;
               iorw   = 1'b1;
               ioaddr = ADDR_DATA;
            end
         endcase
      end
   end

   // Sequencer, round-robin grant, config request and RX holding register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= CFG_LO;
         rst_q       <= 1'b1;
         cfg_pending <= 1'b0;
         last_grant  <= GNT_TX;
         rx_valid    <= 1'b0;
         rx_data     <= 8'h00;
         br_q        <= br_cfg;
      end else begin
         rst_q <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         if (cfg_req && !cfg_busy) cfg_pending <= 1'b1;
         case (state)
            CFG_LO: begin
               if (!rst_q) state <= CFG_HI;
            end
            CFG_HI: state <= IDLE;
            IDLE: begin
               if (cfg_pending) begin
                  state       <= CFG_LO;
                  br_q        <= br_cfg;
                  cfg_pending <= 1'b0;
               end else if (rx_ok && (!tx_ok || last_grant == GNT_TX)) begin
                  state      <= RD_RX;
                  last_grant <= GNT_RX;
               end else if (tx_ok) begin
                  state      <= WR_TX;
                  last_grant <= GNT_TX;
               end
            end
            RD_RX: begin
               rx_data  <= databus;
               rx_valid <= 1'b1;
               state    <= IDLE;
            end
            WR_TX: state <= IDLE;
            default: state <= CFG_LO;
         endcase
      end
   end

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter with a tiny SPART read-side model.
// Bus accesses are logged at negedge and compared with hand-computed values.
module tb_spart_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] br_cfg;
   logic       cfg_req;
   logic       cfg_busy;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;
   wire  [7:0] databus;
   logic [7:0] sp_byte;

   typedef struct {
      int         t;
      logic       rw;
      logic [1:0] a;
      logic [7:0] d;
   } acc_t;

   acc_t acc_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   assign databus = (iocs && iorw) ? sp_byte : 8'hzz;

   spart_bus_arbiter #(.TX_DEPTH(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .br_cfg  (br_cfg),
      .cfg_req (cfg_req),
      .cfg_busy(cfg_busy),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .rda     (rda),
      .tbr     (tbr),
      .databus (databus)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (iocs === 1'b1) acc_q.push_back('{cyc, iorw, ioaddr, databus});
   end

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_iocs"}, 16'(iocs), 16'h0);
      chk({tag, "_iorw"}, 16'(iorw), 16'h1);
      chk({tag, "_addr"}, 16'(ioaddr), 16'h0);
      chk({tag, "_busy"}, 16'(cfg_busy), 16'h1);
      chk({tag, "_rxv"}, 16'(rx_valid), 16'h0);
      chk({tag, "_rxd"}, 16'(rx_data), 16'h0);
      chk({tag, "_txr"}, 16'(tx_ready), 16'h1);
   endtask

   task automatic chk_cfg(input string tag, input logic [15:0] dv);
      step(1);
      chk({tag, "_lo_a"}, 16'(ioaddr), 16'h2);
      chk({tag, "_lo_rw"}, 16'(iorw), 16'h0);
      chk({tag, "_lo_cs"}, 16'(iocs), 16'h1);
      chk({tag, "_lo_d"}, 16'(databus), 16'(dv[7:0]));
      step(1);
      chk({tag, "_hi_a"}, 16'(ioaddr), 16'h3);
      chk({tag, "_hi_d"}, 16'(databus), 16'(dv[15:8]));
      step(1);
      chk({tag, "_idle_cs"}, 16'(iocs), 16'h0);
      chk({tag, "_idle_busy"}, 16'(cfg_busy), 16'h0);
   endtask

   task automatic push_byte(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      step(1);
      tx_valid = 1'b0;
   endtask

   logic [7:0] v5 [5];
   bit         found;

   initial begin
      rst_n = 1'b0; br_cfg = 2'b01; cfg_req = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
      rda = 1'b0; tbr = 1'b0; sp_byte = 8'h00;

      // 1: reset and 9600 divisor load
      step(2);
      chk_reset("t1_rst");
      rst_n = 1'b1;
      chk_cfg("t1", 16'h028B);

      // 2: single TX write
      acc_q.delete();
      tbr = 1'b1;
      push_byte(8'h41);
      step(8);
      chk("t2_n", 16'(acc_q.size()), 16'd1);
      if (acc_q.size() >= 1) begin
         chk("t2_rw", 16'(acc_q[0].rw), 16'h0);
         chk("t2_a", 16'(acc_q[0].a), 16'h0);
         chk("t2_d", 16'(acc_q[0].d), 16'h41);
      end

      // 3: RX read with backpressure
      tbr = 1'b0; rda = 1'b1; sp_byte = 8'h5A;
      acc_q.delete();
      step(10);
      chk("t3_n", 16'(acc_q.size()), 16'd1);
      if (acc_q.size() >= 1) chk("t3_rw", 16'(acc_q[0].rw), 16'h1);
      chk("t3_rxv", 16'(rx_valid), 16'h1);
      chk("t3_rxd", 16'(rx_data), 16'h5A);
      rda = 1'b0; rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
      chk("t3_consumed", 16'(rx_valid), 16'h0);

      // 4: round-robin after a fresh reset
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(4);
      push_byte(8'hA1);
      push_byte(8'hA2);
      push_byte(8'hA3);
      acc_q.delete();
      sp_byte = 8'hC3; rda = 1'b1; tbr = 1'b1; rx_ready = 1'b1;
      step(14);
      rda = 1'b0; tbr = 1'b0;
      step(3);
      chk("t4_n", 16'(acc_q.size() >= 6), 16'h1);
      for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
         chk($sformatf("t4_rw%0d", i), 16'(acc_q[i].rw),
             (i % 2 == 0) ? 16'h1 : 16'h0);
         chk($sformatf("t4_d%0d", i), 16'(acc_q[i].d),
             (i % 2 == 0) ? 16'hC3 : 16'(8'hA1 + i / 2));
         if (i > 0)
            chk($sformatf("t4_gap%0d", i),
                16'(acc_q[i].t - acc_q[i-1].t), 16'd2);
      end
      rx_ready = 1'b0;

      // 5: fill, overflow drop, drain in order
      v5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) begin
         tx_data = v5[i]; tx_valid = 1'b1;
         step(1);
         chk($sformatf("t5_rdy%0d", i), 16'(tx_ready),
             (i < 3) ? 16'h1 : 16'h0);
      end
      tx_valid = 1'b0;
      acc_q.delete();
      tbr = 1'b1;
      step(12);
      tbr = 1'b0;
      chk("t5_n", 16'(acc_q.size()), 16'd4);
      for (int i = 0; i < 4 && i < acc_q.size(); i++)
         chk($sformatf("t5_d%0d", i), 16'(acc_q[i].d), 16'(v5[i]));
      chk("t5_rdy_end", 16'(tx_ready), 16'h1);

      // 6a: reconfigure requested during a TX write
      push_byte(8'h66);
      push_byte(8'h77);
      acc_q.delete();
      tbr = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1);
         if (iocs && !iorw && ioaddr == 2'b00) found = 1'b1;
      end
      chk("t6_wait_wr", 16'(found), 16'h1);
      br_cfg = 2'b11; cfg_req = 1'b1;
      step(1);
      cfg_req = 1'b0;
      step(10);
      tbr = 1'b0;
      chk("t6_n", 16'(acc_q.size()), 16'd4);
      if (acc_q.size() >= 4) begin
         chk("t6_a0", 16'({acc_q[0].a, acc_q[0].d}), 16'h066);
         chk("t6_a1", 16'({acc_q[1].a, acc_q[1].d}), 16'h2A3);
         chk("t6_a2", 16'({acc_q[2].a, acc_q[2].d}), 16'h300);
         chk("t6_a3", 16'({acc_q[3].a, acc_q[3].d}), 16'h077);
      end

      // 6b: reset in the middle of an RX read
      sp_byte = 8'h99; rda = 1'b1; br_cfg = 2'b00;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1);
         if (iocs && iorw) found = 1'b1;
      end
      chk("t6_wait_rd", 16'(found), 16'h1);
      rst_n = 1'b0;
      step(1);
      chk_reset("t6_rst");
      rda = 1'b0; rst_n = 1'b1;
      chk_cfg("t6_cfg", 16'h0516);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
